// File: rtl/kernel_host_pkg.sv
// ============================================================================
// Module      : kernel_host_pkg
// Description : Shared types and parameter defaults for the kernel host driver.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package kernel_host_pkg;

    localparam int c_def_width          = 32;
    localparam int c_def_cnt_w          = 16;
    localparam int c_def_rst_cycles     = 2;
    localparam int c_def_pipe_depth     = 2;
    localparam int c_def_timeout_cycles = 1000;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        KRST   = 3'd1,
        SETTLE = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/kernel_host_ctrl_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Up-counter with synchronous clear that sticks at all-ones.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count_next
);

    logic [W-1:0] r_count;

    // The next value is exported so a capture on the same edge sees this cycle's increment.
    always_comb begin
        count_next = r_count;
        if (clr) begin
            count_next = '0;
        end else if (inc && (r_count != '1)) begin
            count_next = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= count_next;
        end
    end

endmodule

`default_nettype wire

// File: rtl/kernel_host_ctrl.sv
// ============================================================================
// Module      : kernel_host_ctrl
// Description : Host-side run sequencer for a mapped CGRA dataflow kernel.
//               Optional watchdog enabled by defining KERNEL_HOST_TIMEOUT_EN.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module kernel_host_ctrl
    import kernel_host_pkg::*;
#(
    parameter int WIDTH          = c_def_width,
    parameter int CNT_W          = c_def_cnt_w,
    parameter int RST_CYCLES     = c_def_rst_cycles,
    parameter int PIPE_DEPTH     = c_def_pipe_depth,
    parameter int TIMEOUT_CYCLES = c_def_timeout_cycles
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [WIDTH-1:0] start_bound,
    output logic             kern_en,
    output logic             kern_rst,
    output logic [WIDTH-1:0] kern_in,
    input  logic             kern_br,
    input  logic [WIDTH-1:0] kern_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic [CNT_W-1:0] res_cycles,
    output logic             res_timeout
);

    localparam int c_dmax = (RST_CYCLES > PIPE_DEPTH) ? RST_CYCLES : PIPE_DEPTH;
    localparam int c_dw   = (c_dmax > 1) ? $clog2(c_dmax) : 1;
    localparam logic [c_dw-1:0] c_rst_load  = c_dw'(RST_CYCLES - 1);
    localparam logic [c_dw-1:0] c_pipe_load = c_dw'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

    state_t            r_state;
    logic [c_dw-1:0]   r_dcnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic              w_accept;

    assign w_accept = (r_state == IDLE) && start_valid && start_ready;

    sat_counter #(
        .W (CNT_W)
    ) u_run_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (w_accept),
        .inc        (kern_en),
        .count_next (w_cnt_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_dcnt      <= '0;
            start_ready <= 1'b0;
            kern_en     <= 1'b0;
            kern_rst    <= 1'b1;
            kern_in     <= '0;
            res_valid   <= 1'b0;
            res_data    <= '0;
            res_cycles  <= '0;
            res_timeout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    kern_en  <= 1'b0;
                    kern_rst <= 1'b0;
                    if (w_accept) begin
                        start_ready <= 1'b0;
                        kern_in     <= start_bound;
                        kern_rst    <= 1'b1;
                        r_dcnt      <= c_rst_load;
                        r_state     <= KRST;
                    end else begin
                        start_ready <= 1'b1;
                    end
                end
                KRST: begin
                    if (r_dcnt == '0) begin
                        kern_rst <= 1'b0;
                        kern_en  <= 1'b1;
                        if (PIPE_DEPTH == 0) begin
                            r_state <= RUN;
                        end else begin
                            r_dcnt  <= c_pipe_load;
                            r_state <= SETTLE;
                        end
                    end else begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end
                end
                SETTLE: begin
                    // Branch flag is meaningless while the kernel pipeline fills.
                    if (r_dcnt == '0) begin
                        r_state <= RUN;
                    end else begin
                        r_dcnt <= r_dcnt - 1'b1;
                    end
                end
                RUN: begin
                    if (kern_br) begin
                        kern_en     <= 1'b0;
                        res_valid   <= 1'b1;
                        res_data    <= kern_out;
                        res_cycles  <= w_cnt_next;
                        res_timeout <= 1'b0;
                        r_state     <= DONE;
                    end
`ifdef KERNEL_HOST_TIMEOUT_EN
                    else if (32'(w_cnt_next) >= TIMEOUT_CYCLES) begin
                        kern_en     <= 1'b0;
                        res_valid   <= 1'b1;
                        res_data    <= kern_out;
                        res_cycles  <= w_cnt_next;
                        res_timeout <= 1'b1;
                        r_state     <= DONE;
                    end
`endif
                end
                DONE: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_kernel_host_ctrl.sv
// ============================================================================
// Module      : tb_kernel_host_ctrl
// Description : Directed self-checking bench for kernel_host_ctrl.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_kernel_host_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        sat_sel = 1'b0;
    logic [31:0] start_bound = '0;
    logic        kern_br = 1'b0;
    logic [31:0] kern_out = '0;
    logic        res_ready = 1'b0;

    logic        start_ready, kern_en, kern_rst, res_valid, res_timeout;
    logic [31:0] kern_in, res_data;
    logic [15:0] res_cycles;

    logic        s_start_ready, s_kern_en, s_kern_rst, s_res_valid, s_res_timeout;
    logic [31:0] s_kern_in, s_res_data;
    logic [3:0]  s_res_cycles;

    logic m_sv, s_sv, c_en, c_rst, c_rv, c_sr;
    assign m_sv  = start_valid & ~sat_sel;
    assign s_sv  = start_valid & sat_sel;
    assign c_en  = sat_sel ? s_kern_en     : kern_en;
    assign c_rst = sat_sel ? s_kern_rst    : kern_rst;
    assign c_rv  = sat_sel ? s_res_valid   : res_valid;
    assign c_sr  = sat_sel ? s_start_ready : start_ready;

    int n_pass = 0;
    int n_chk  = 0;

    always #5 clk = ~clk;

    kernel_host_ctrl #(
        .WIDTH(32), .CNT_W(16), .RST_CYCLES(2), .PIPE_DEPTH(2), .TIMEOUT_CYCLES(20)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(m_sv), .start_ready(start_ready), .start_bound(start_bound),
        .kern_en(kern_en), .kern_rst(kern_rst), .kern_in(kern_in),
        .kern_br(kern_br), .kern_out(kern_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_cycles(res_cycles), .res_timeout(res_timeout)
    );

    kernel_host_ctrl #(
        .WIDTH(32), .CNT_W(4), .RST_CYCLES(2), .PIPE_DEPTH(2), .TIMEOUT_CYCLES(1000)
    ) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .start_valid(s_sv), .start_ready(s_start_ready), .start_bound(start_bound),
        .kern_en(s_kern_en), .kern_rst(s_kern_rst), .kern_in(s_kern_in),
        .kern_br(kern_br), .kern_out(kern_out),
        .res_valid(s_res_valid), .res_ready(res_ready), .res_data(s_res_data),
        .res_cycles(s_res_cycles), .res_timeout(s_res_timeout)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [31:0] b);
        start_bound = b;
        start_valid = 1'b1;
        for (int i = 0; i < 20 && !c_sr; i++) step();
        n_chk++; if (c_sr !== 1'b1) $display("FAIL start_ready_wait: got %b want 1", c_sr); else n_pass++;
        step();
        start_valid = 1'b0;
    endtask

    // Kernel model: raises kern_br during the br_at-th enabled cycle (or every enabled cycle when hold).
    task automatic drive_run(input int br_at, input logic hold, input logic [31:0] outv,
                             output int rst_cnt, output int en_cnt);
        logic ok;
        rst_cnt = 0; en_cnt = 0; ok = 1'b0;
        kern_out = outv;
        for (int i = 0; i < 200; i++) begin
            if (c_rv) begin ok = 1'b1; break; end
            if (c_rst) rst_cnt++;
            if (c_en)  en_cnt++;
            kern_br = hold ? c_en : (br_at != 0 && c_en && en_cnt == br_at);
            step();
        end
        kern_br = 1'b0;
        n_chk++; if (ok !== 1'b1) $display("FAIL run_done: res_valid got %b want 1 within budget", ok); else n_pass++;
        n_chk++; if (c_en !== 1'b0) $display("FAIL done_kern_en: got %b want 0", c_en); else n_pass++;
    endtask

    task automatic handshake();
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        n_chk++; if ({c_rv, c_sr} !== 2'b00) $display("FAIL post_accept: valid/ready got %b want 00", {c_rv, c_sr}); else n_pass++;
        step();
        n_chk++; if (c_sr !== 1'b1) $display("FAIL idle_ready: got %b want 1", c_sr); else n_pass++;
    endtask

    task automatic test_reset();
        step(); step();
        n_chk++; if ({kern_rst, kern_en, start_ready, res_valid, res_timeout} !== 5'b10000)
            $display("FAIL reset_ctrl: got %b want 10000", {kern_rst, kern_en, start_ready, res_valid, res_timeout}); else n_pass++;
        n_chk++; if ({kern_in, res_data, res_cycles} !== 80'd0)
            $display("FAIL reset_data: got %h want 0", {kern_in, res_data, res_cycles}); else n_pass++;
        rst_n = 1'b1;
        #1;
        n_chk++; if (start_ready !== 1'b0) $display("FAIL release_ready: got %b want 0", start_ready); else n_pass++;
        step();
        n_chk++; if ({start_ready, kern_rst} !== 2'b10) $display("FAIL first_edge: got %b want 10", {start_ready, kern_rst}); else n_pass++;
    endtask

    task automatic test_basic();
        int rc, ec;
        do_start(32'd5);
        n_chk++; if (kern_in !== 32'd5) $display("FAIL basic_kern_in: got %0d want 5", kern_in); else n_pass++;
        drive_run(7, 1'b0, 32'h2A, rc, ec);
        n_chk++; if (rc !== 2) $display("FAIL basic_rst_cycles: got %0d want 2", rc); else n_pass++;
        n_chk++; if (ec !== 7) $display("FAIL basic_en_cycles: got %0d want 7", ec); else n_pass++;
        n_chk++; if (res_data !== 32'h2A) $display("FAIL basic_data: got %h want 2a", res_data); else n_pass++;
        n_chk++; if (res_cycles !== 16'd7) $display("FAIL basic_cycles: got %0d want 7", res_cycles); else n_pass++;
        n_chk++; if (res_timeout !== 1'b0) $display("FAIL basic_timeout: got %b want 0", res_timeout); else n_pass++;
        handshake();
    endtask

    task automatic test_early_flag();
        int rc, ec;
        do_start(32'd9);
        drive_run(0, 1'b1, 32'h55, rc, ec);
        n_chk++; if (ec !== 3) $display("FAIL early_en_cycles: got %0d want 3", ec); else n_pass++;
        n_chk++; if (res_cycles !== 16'd3) $display("FAIL early_cycles: got %0d want 3", res_cycles); else n_pass++;
        n_chk++; if (res_data !== 32'h55) $display("FAIL early_data: got %h want 55", res_data); else n_pass++;
        handshake();
    endtask

    task automatic test_backpressure();
        int rc, ec;
        logic [82:0] exp_v;
        do_start(32'd3);
        drive_run(4, 1'b0, 32'h77, rc, ec);
        exp_v = {1'b1, 32'h77, 16'd4, 1'b0, 1'b0, 32'd3};
        start_bound = 32'hDEAD;
        for (int i = 0; i < 10; i++) begin
            start_valid = (i % 2 == 0);
            step();
            n_chk++; if ({res_valid, res_data, res_cycles, start_ready, kern_rst, kern_in} !== exp_v)
                $display("FAIL bp_hold[%0d]: got %h want %h", i,
                         {res_valid, res_data, res_cycles, start_ready, kern_rst, kern_in}, exp_v);
            else n_pass++;
        end
        start_valid = 1'b0;
        handshake();
    endtask

`ifdef KERNEL_HOST_TIMEOUT_EN
    task automatic test_timeout();
        int rc, ec;
        do_start(32'd1);
        drive_run(0, 1'b0, 32'h99, rc, ec);
        n_chk++; if (res_timeout !== 1'b1) $display("FAIL to_flag: got %b want 1", res_timeout); else n_pass++;
        n_chk++; if (res_cycles !== 16'd20) $display("FAIL to_cycles: got %0d want 20", res_cycles); else n_pass++;
        n_chk++; if (res_data !== 32'h99) $display("FAIL to_data: got %h want 99", res_data); else n_pass++;
        handshake();
        do_start(32'd2);
        drive_run(20, 1'b0, 32'h11, rc, ec);
        n_chk++; if (res_timeout !== 1'b0) $display("FAIL to_tie_flag: got %b want 0", res_timeout); else n_pass++;
        n_chk++; if (res_cycles !== 16'd20) $display("FAIL to_tie_cycles: got %0d want 20", res_cycles); else n_pass++;
        n_chk++; if (res_data !== 32'h11) $display("FAIL to_tie_data: got %h want 11", res_data); else n_pass++;
        handshake();
    endtask
`else
    task automatic test_long_run();
        int rc, ec;
        do_start(32'd2);
        drive_run(25, 1'b0, 32'h11, rc, ec);
        n_chk++; if (res_timeout !== 1'b0) $display("FAIL long_flag: got %b want 0", res_timeout); else n_pass++;
        n_chk++; if (res_cycles !== 16'd25) $display("FAIL long_cycles: got %0d want 25", res_cycles); else n_pass++;
        handshake();
    endtask
`endif

    task automatic test_saturation();
        int rc, ec;
        sat_sel = 1'b1;
        do_start(32'd7);
        drive_run(30, 1'b0, 32'h3C, rc, ec);
        n_chk++; if (ec !== 30) $display("FAIL sat_en_cycles: got %0d want 30", ec); else n_pass++;
        n_chk++; if (s_res_cycles !== 4'd15) $display("FAIL sat_cycles: got %0d want 15", s_res_cycles); else n_pass++;
        n_chk++; if (s_res_data !== 32'h3C) $display("FAIL sat_data: got %h want 3c", s_res_data); else n_pass++;
        handshake();
        sat_sel = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int rc, ec;
        do_start(32'd4);
        for (int i = 0; i < 8; i++) step();
        n_chk++; if (kern_en !== 1'b1) $display("FAIL mid_running: kern_en got %b want 1", kern_en); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_chk++; if ({kern_en, kern_rst, res_valid, start_ready} !== 4'b0100)
            $display("FAIL mid_reset: got %b want 0100", {kern_en, kern_rst, res_valid, start_ready}); else n_pass++;
        n_chk++; if (kern_in !== 32'd0) $display("FAIL mid_kern_in: got %0d want 0", kern_in); else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        do_start(32'd6);
        drive_run(5, 1'b0, 32'h5A, rc, ec);
        n_chk++; if (rc !== 2) $display("FAIL rerun_rst_cycles: got %0d want 2", rc); else n_pass++;
        n_chk++; if (res_cycles !== 16'd5) $display("FAIL rerun_cycles: got %0d want 5", res_cycles); else n_pass++;
        n_chk++; if (res_data !== 32'h5A) $display("FAIL rerun_data: got %h want 5a", res_data); else n_pass++;
        handshake();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_early_flag();
        test_backpressure();
`ifdef KERNEL_HOST_TIMEOUT_EN
        test_timeout();
`else
        test_long_run();
`endif
        test_saturation();
        test_reset_mid_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
